// File: rtl/tlc_pkg.sv
// Shared light codes, phase-state encoding and an index-width helper for the phase scheduler.
package tlc_pkg;

  localparam logic [1:0] LT_GREEN  = 2'd0;
  localparam logic [1:0] LT_YELLOW = 2'd1;
  localparam logic [1:0] LT_RED    = 2'd2;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_state_e;

  // Width of a phase index; kept at least 1 bit so a single-phase build still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Sensor/prescaler inputs and light-driver outputs of the phase scheduler.
// There is no valid/ready handshake on this bundle: tick, peak and demand are sampled on
// every clock edge, and grant is a one-cycle strobe that cannot be back-pressured.
interface tlc_phase_scheduler_if #(
  parameter int NUM_PH = 4
);
  import tlc_pkg::*;

  localparam int AW = idx_w(NUM_PH);

  logic                  tick;
  logic                  peak;
  logic [NUM_PH-1:0]     demand;
  logic [2*NUM_PH-1:0]   lights;
  logic [AW-1:0]         active_phase;
  logic [1:0]            phase_state;
  logic                  grant;

  modport master (
    output tick, peak, demand,
    input  lights, active_phase, phase_state, grant
  );

  modport slave (
    input  tick, peak, demand,
    output lights, active_phase, phase_state, grant
  );

endinterface

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping around,
// with 'last' itself considered only at the end of the sweep.
module tlc_rr_pick #(
  parameter int NUM_PH = 4,
  parameter int AW     = 2
) (
  input  logic [NUM_PH-1:0] req,
  input  logic [AW-1:0]     last,
  output logic              valid,
  output logic [AW-1:0]     idx
);

  // Sweep offsets 1..NUM_PH from last and keep the first hit.
  always_comb begin : search
    logic [AW-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_PH; k++) begin
      cand = AW'((int'(last) + k) % NUM_PH);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven intersection phase scheduler: GREEN -> YELLOW -> ALL_RED per grant, with
// round-robin selection among phases holding latched demand.
module tlc_phase_scheduler #(
  parameter int NUM_PH        = 4,
  parameter int GREEN_OFFPEAK = 16,
  parameter int GREEN_PEAK    = 32,
  parameter int YELLOW_T      = 4,
  parameter int ALLRED_T      = 2,
  parameter int TW            = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  tlc_phase_scheduler_if.slave  bus
);
  import tlc_pkg::*;

  localparam int AW = idx_w(NUM_PH);

  phase_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         dur, green_dur;
  logic                  expired;
  logic                  peak_q, peak_d;
  logic [NUM_PH-1:0]     dq_q, dq_d;
  logic [NUM_PH-1:0]     others;
  logic [AW-1:0]         active_q, active_d;
  logic [2*NUM_PH-1:0]   lights_q, lights_d;
  logic                  grant_q, grant_d;
  logic                  pick_valid;
  logic [AW-1:0]         pick_idx;

  tlc_rr_pick #(.NUM_PH(NUM_PH), .AW(AW)) u_pick (
    .req   (dq_q),
    .last  (active_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Duration of the current state; the timer saturates at dur so an expired state stays
  // distinguishable from one still waiting for its last tick.
  always_comb begin
    green_dur = peak_q ? TW'(GREEN_PEAK) : TW'(GREEN_OFFPEAK);
    case (state_q)
      ST_GREEN:  dur = green_dur;
      ST_YELLOW: dur = TW'(YELLOW_T);
      default:   dur = TW'(ALLRED_T);
    endcase
    expired = (timer_q == dur) || (bus.tick && (timer_q == dur - 1'b1));
  end

  // Demand from phases other than the one currently granted.
  always_comb begin
    others = '0;
    for (int i = 0; i < NUM_PH; i++) begin
      others[i] = dq_q[i] && (AW'(i) != active_q);
    end
  end

  // Next state, timer, grant, peak latch, demand latches and registered light codes.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    peak_d   = peak_q;
    grant_d  = 1'b0;
    timer_d  = (bus.tick && (timer_q != dur)) ? timer_q + 1'b1 : timer_q;
    case (state_q)
      ST_ALLRED: begin
        if (expired && pick_valid) begin
          state_d  = ST_GREEN;
          active_d = pick_idx;
          peak_d   = bus.peak;
          grant_d  = 1'b1;
        end
      end
      ST_GREEN:  if (expired && (|others)) state_d = ST_YELLOW;
      ST_YELLOW: if (expired) state_d = ST_ALLRED;
      default:   state_d = ST_ALLRED;
    endcase
    if (state_d != state_q) timer_d = '0;

    // A phase's own green masks its sensor; the grant edge clears and beats a new set.
    for (int i = 0; i < NUM_PH; i++) begin
      dq_d[i] = (dq_q[i] || (bus.demand[i] &&
                 !((state_q == ST_GREEN) && (active_q == AW'(i)))))
                && !(grant_d && (active_d == AW'(i)));
    end

    lights_d = {NUM_PH{LT_RED}};
    for (int i = 0; i < NUM_PH; i++) begin
      if (AW'(i) == active_d) begin
        if (state_d == ST_GREEN)       lights_d[2*i +: 2] = LT_GREEN;
        else if (state_d == ST_YELLOW) lights_d[2*i +: 2] = LT_YELLOW;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ALLRED;
      timer_q  <= '0;
      peak_q   <= 1'b0;
      dq_q     <= '0;
      active_q <= AW'(NUM_PH - 1);
      lights_q <= {NUM_PH{LT_RED}};
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      peak_q   <= peak_d;
      dq_q     <= dq_d;
      active_q <= active_d;
      lights_q <= lights_d;
      grant_q  <= grant_d;
    end
  end

  assign bus.lights       = lights_q;
  assign bus.active_phase = active_q;
  assign bus.phase_state  = state_q;
  assign bus.grant        = grant_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: a cycle table for reset and single-demand
// sequencing, then hand-written sequences for round robin, peak, mid-yellow reset and
// coincident demand/grant events.
module tb_tlc_phase_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlc_phase_scheduler_if #(.NUM_PH(4)) bus ();

  tlc_phase_scheduler #(
    .NUM_PH(4), .GREEN_OFFPEAK(16), .GREEN_PEAK(32),
    .YELLOW_T(4), .ALLRED_T(2), .TW(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int gcnt, ycnt, rcnt;

  typedef struct {
    logic       rst;
    logic       tk;
    logic [3:0] dm;
    int         idle;
    logic [7:0] lights;
    logic [1:0] st;
    logic [1:0] act;
    logic       gr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic tk, input logic [3:0] dm,
                              input int idle, input logic [7:0] l, input logic [1:0] s,
                              input logic [1:0] a, input logic g);
    vec_t v;
    v.rst = rst; v.tk = tk; v.dm = dm; v.idle = idle;
    v.lights = l; v.st = s; v.act = a; v.gr = g;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic tk, input logic pk, input logic [3:0] dm);
    reset      = rst;
    bus.tick   = tk;
    bus.peak   = pk;
    bus.demand = dm;
    @(posedge clk);
    #1;
    case (bus.phase_state)
      2'd0:    rcnt++;
      2'd1:    gcnt++;
      2'd2:    ycnt++;
      default: ;
    endcase
  endtask

  task automatic clear_cnt();
    gcnt = 0; ycnt = 0; rcnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [7:0] l, input logic [1:0] s,
                           input logic [1:0] a, input logic g);
    check({nm, ".lights"}, 32'(bus.lights), 32'(l));
    check({nm, ".state"},  32'(bus.phase_state), 32'(s));
    check({nm, ".active"}, 32'(bus.active_phase), 32'(a));
    check({nm, ".grant"},  32'(bus.grant), 32'(g));
  endtask

  task automatic wait_grant(input int budget, input logic pk, input logic [3:0] dm,
                            input string nm);
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 1'b1, pk, dm);
      if (bus.grant === 1'b1) break;
    end
    n_checks++;
    if (bus.grant !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no grant within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gr_seen;
    logic [1:0] rr_order [4];
    rr_order[0] = 2'd1; rr_order[1] = 2'd2; rr_order[2] = 2'd3; rr_order[3] = 2'd0;
    reset = 1'b1; bus.tick = 1'b0; bus.peak = 1'b0; bus.demand = '0;
    clear_cnt();

    // ---------------- table: reset and single-demand sequencing ----------------
    vecs.push_back(mk(1, 1, 4'hF, 0, 8'hAA, 0, 3, 0));
    vecs.push_back(mk(1, 1, 4'hF, 0, 8'hAA, 0, 3, 0));
    vecs.push_back(mk(0, 0, 4'h4, 0, 8'hAA, 0, 3, 0));
    vecs.push_back(mk(0, 1, 4'h0, 3, 8'hAA, 0, 3, 0));
    vecs.push_back(mk(0, 1, 4'h0, 0, 8'h8A, 1, 2, 1));
    vecs.push_back(mk(0, 0, 4'h0, 2, 8'h8A, 1, 2, 0));
    for (int t = 0; t < 16; t++) vecs.push_back(mk(0, 1, 4'h0, 3, 8'h8A, 1, 2, 0));
    vecs.push_back(mk(0, 0, 4'h1, 0, 8'h8A, 1, 2, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 8'h9A, 2, 2, 0));
    for (int t = 0; t < 3; t++) vecs.push_back(mk(0, 1, 4'h0, 3, 8'h9A, 2, 2, 0));
    vecs.push_back(mk(0, 1, 4'h0, 3, 8'hAA, 0, 2, 0));
    vecs.push_back(mk(0, 1, 4'h0, 3, 8'hAA, 0, 2, 0));
    vecs.push_back(mk(0, 1, 4'h0, 0, 8'hA8, 1, 0, 1));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].tk, 1'b0, vecs[k].dm);
      for (int j = 0; j < vecs[k].idle; j++) step(1'b0, 1'b0, 1'b0, 4'h0);
      check_out($sformatf("vec%0d", k), vecs[k].lights, vecs[k].st, vecs[k].act, vecs[k].gr);
    end

    // ---------------- round robin with all demand held ----------------
    step(1, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    wait_grant(10, 1'b0, 4'hF, "rr_first");
    check("rr_first.active", 32'(bus.active_phase), 32'd0);
    for (int p = 0; p < 4; p++) begin
      clear_cnt();
      wait_grant(40, 1'b0, 4'hF, $sformatf("rr%0d", p));
      check($sformatf("rr%0d.active", p), 32'(bus.active_phase), 32'(rr_order[p]));
      check($sformatf("rr%0d.green", p),  32'(gcnt), 32'd16);
      check($sformatf("rr%0d.yellow", p), 32'(ycnt), 32'd4);
      check($sformatf("rr%0d.allred", p), 32'(rcnt), 32'd2);
    end
    step(0, 1, 0, 4'hF);
    check("rr.grant_pulse", 32'(bus.grant), 32'd0);

    // ---------------- peak sampled only at grant ----------------
    step(1, 0, 0, 4'h0);
    wait_grant(10, 1'b1, 4'h3, "peak_g0");
    check("peak_g0.active", 32'(bus.active_phase), 32'd0);
    clear_cnt();
    for (int t = 0; t < 5; t++) step(0, 1, 1, 4'h3);
    wait_grant(60, 1'b0, 4'h3, "peak_g1");
    check("peak_g1.active", 32'(bus.active_phase), 32'd1);
    check("peak.green32",   32'(gcnt), 32'd32);
    check("peak.yellow",    32'(ycnt), 32'd4);
    clear_cnt();
    wait_grant(40, 1'b0, 4'h3, "peak_g2");
    check("peak_g2.active", 32'(bus.active_phase), 32'd0);
    check("offpeak.green16", 32'(gcnt), 32'd16);

    // ---------------- reset in the middle of yellow ----------------
    step(1, 0, 0, 4'h0);
    wait_grant(10, 1'b0, 4'h3, "myr_g0");
    for (int t = 0; t < 16; t++) step(0, 1, 0, 4'h3);
    check("myr.in_yellow", 32'(bus.phase_state), 32'd2);
    step(0, 1, 0, 4'h3);
    step(0, 1, 0, 4'h3);
    step(1, 1, 0, 4'h3);
    check_out("myr.reset", 8'hAA, 2'd0, 2'd3, 1'b0);
    step(0, 0, 0, 4'h8);
    gr_seen = 0;
    for (int t = 0; t < 4; t++) begin
      step(0, 0, 0, 4'h0);
      if (bus.grant === 1'b1) gr_seen++;
    end
    step(0, 1, 0, 4'h0);
    if (bus.grant === 1'b1) gr_seen++;
    check("myr.no_early_grant", 32'(gr_seen), 32'd0);
    step(0, 1, 0, 4'h0);
    check_out("myr.grant3", 8'h2A, 2'd1, 2'd3, 1'b1);

    // ---------------- coincident demand/grant and demand during own green ----------------
    step(1, 0, 0, 4'h0);
    step(0, 0, 0, 4'h1);
    step(0, 1, 0, 4'h0);
    step(0, 1, 0, 4'h3);
    check_out("coin.grant0", 8'hA8, 2'd1, 2'd0, 1'b1);
    wait_grant(40, 1'b0, 4'h0, "coin_g1");
    check("coin_g1.active", 32'(bus.active_phase), 32'd1);
    gr_seen = 0;
    for (int t = 0; t < 40; t++) begin
      step(0, 1, 0, (t == 3 || t == 10) ? 4'h2 : 4'h0);
      if (bus.grant === 1'b1) gr_seen++;
    end
    check("coin.no_regrant", 32'(gr_seen), 32'd0);
    check_out("coin.rest_green", 8'hA2, 2'd1, 2'd1, 1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
